// File: rtl/gcdn_top.sv
// gcdn_top: N-operand greatest-common-divisor engine.
// A single subtractive-Euclid datapath processes one step per cycle. It folds the
// operands left to right: gcd(gcd(gcd(op0,op1),op2),...).
// A one-cycle start pulse launches a job. The result appears on D with a one-cycle
// valid strobe, and D holds that value until the next result.
// Optional build macro: GCDN_EARLY_EXIT_EN. When it is defined, the engine finishes
// as soon as an intermediate gcd equals 1.
//
// state | meaning
// IDLE  | waiting for start; operands are latched on start
// CALC  | one subtract/compare step per cycle on (a, b)
// DONE  | result strobe cycle; start is ignored here
module gcdn_top #(
   parameter int WIDTH = 16,
   parameter int N     = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N*WIDTH-1:0] ops,
   output logic               busy,
   output logic               valid,
   output logic [WIDTH-1:0]   D
);

   // Reject illegal parameterisations at elaboration time.
   generate
      if (N < 2 || N > 16 || WIDTH < 2 || WIDTH > 32) begin : g_param_err
         $error("gcdn_top: N must be 2..16 and WIDTH must be 2..32");
      end
   endgenerate

   localparam int IDXW  = $clog2(N);
   localparam int DEPTH = 1 << IDXW;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [WIDTH-1:0]  r_op [0:DEPTH-1];
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_d;
   logic [IDXW-1:0]   r_idx;

   logic              w_term;
   logic              w_last;
   logic [WIDTH-1:0]  w_r;
   logic [IDXW-1:0]   w_idx_nxt;

   assign w_idx_nxt = r_idx + 1'b1;
   assign D         = r_d;

   // Pair termination test and the pair result r, checked in priority order.
   always_comb begin
      w_term = 1'b0;
      w_r    = r_a;
      if (r_a == '0) begin
         w_term = 1'b1;
         w_r    = r_b;
      end else if (r_b == '0 || r_a == r_b) begin
         w_term = 1'b1;
         w_r    = r_a;
      end
   end

`ifdef GCDN_EARLY_EXIT_EN
   // A gcd of 1 cannot shrink further, so the remaining operands are skipped.
   assign w_last = (r_idx == LAST_IDX) || (w_r == WIDTH'(1));
`else
   assign w_last = (r_idx == LAST_IDX);
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_CALC;
         S_CALC:  if (w_term && w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      busy  = (r_state != S_IDLE);
      valid = (r_state == S_DONE);
   end

   // Datapath: operand capture, Euclid step, pair chaining and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_d   <= '0;
         r_idx <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_op[IDXW'(k)] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  for (int k = 0; k < N; k++) begin
                     r_op[IDXW'(k)] <= ops[k*WIDTH +: WIDTH];
                  end
                  r_a   <= ops[0 +: WIDTH];
                  r_b   <= ops[WIDTH +: WIDTH];
                  r_idx <= IDXW'(1);
               end
            end
            S_CALC: begin
               if (w_term) begin
                  if (w_last) begin
                     r_d <= w_r;
                  end else begin
                     r_a   <= w_r;
                     r_b   <= r_op[w_idx_nxt];
                     r_idx <= w_idx_nxt;
                  end
               end else if (r_a > r_b) begin
                  r_a <= r_a - r_b;
               end else begin
                  r_b <= r_b - r_a;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
